// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding, baud divider math.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // Clocks per oversample tick, floored, never below one.
    function automatic int tick_div(input int clk_hz, input int baud, input int os);
        int d;
        d = clk_hz / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-clk tick_o every TICK_DIV clocks (tick_o stays high when TICK_DIV is 1).
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int DIV = tick_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: mid-bit 3-sample majority vote, configurable framing,
// 1-entry valid/ready holding register with parity/frame/break status and overrun pulse.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    logic tick;
    logic rx_m_q, rx_s_q;
    rx_state_e state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [BW-1:0] bit_q, bit_d;
    logic stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic v0_q, v0_d, v1_q, v1_d;
    logic par_q, par_d, ferr_q, ferr_d, stop0_q, stop0_d;
    logic armed_q, armed_d, done_q, done_d;
    logic [DATA_BITS-1:0] data_q;
    logic valid_q, perr_q, ferr_out_q, brk_q, ovr_q;
    logic vote, at_vote, wrap, perr_w, brk_w;

    uart_baud_tick #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .tick_o(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
        end
    end

    // The third vote sample is rx_s itself on the tick at S_V2.
    assign vote    = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);
    assign at_vote = (s_q == S_V2);
    assign wrap    = (s_q == S_LAST);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        stop0_d = stop0_q;
        armed_d = armed_q | rx_s_q;
        done_d  = 1'b0;

        if (state_q != ST_IDLE && tick) begin
            s_d = wrap ? '0 : s_q + SW'(1);
            if (s_q == S_V0) v0_d = rx_s_q;
            if (s_q == S_V1) v1_d = rx_s_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick && !rx_s_q && armed_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    par_d   = 1'b0;
                    ferr_d  = 1'b0;
                    stop0_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick && at_vote && vote) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                end else if (tick && wrap) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (at_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (wrap) begin
                        if (bit_q == B_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (tick && at_vote) par_d = vote;
                if (tick && wrap) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick && at_vote) begin
                    if (!vote) ferr_d = 1'b1;
                    if (!stop_q) stop0_d = !vote;
                    // Frame ends at the last stop vote; a low line here blocks re-arming.
                    if (stop_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        s_d     = '0;
                        done_d  = 1'b1;
                        if (!vote) armed_d = 1'b0;
                    end
                end else if (tick && wrap) begin
                    stop_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            stop0_q <= 1'b0;
            armed_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            stop0_q <= stop0_d;
            armed_q <= armed_d;
            done_q  <= done_d;
        end
    end

    assign perr_w = (PARITY == PAR_EVEN) ? (par_q != ^shift_q) :
                    (PARITY == PAR_ODD)  ? (par_q == ^shift_q) : 1'b0;
    assign brk_w  = (shift_q == '0) && !par_q && stop0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done_q) begin
                if (!valid_q || rx_ready) begin
                    data_q     <= shift_q;
                    valid_q    <= 1'b1;
                    perr_q     <= perr_w;
                    ferr_out_q <= ferr_q;
                    brk_q      <= brk_w;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_out_q;
    assign break_det   = brk_q;
    assign overrun_err = ovr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: dut0 is 8N1, dut1 is 8E2; 16 clks per bit.
module tb_uart_rx_os;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rx0, rx1, rdy0, rdy1;
    logic [7:0] d0, d1;
    logic v0, pe0, fe0, bk0, ov0, bz0;
    logic v1, pe1, fe1, bk1, ov1, bz1;

    uart_rx_os #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
        .parity_err(pe0), .frame_err(fe0), .break_det(bk0), .overrun_err(ov0), .busy(bz0));

    uart_rx_os #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
        .parity_err(pe1), .frame_err(fe1), .break_det(bk1), .overrun_err(ov1), .busy(bz1));

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } obs_t;

    typedef struct {
        int         inst;
        logic [7:0] d;
        logic       pbit;
        logic       stop_lvl;
        logic [7:0] ed;
        logic [2:0] eflags;
    } vec_t;

    obs_t cap0[$], cap1[$], exp_q[$];
    int   vhi0, ovr0, n_cmp, n_bad, lat, lat_k;
    logic saw_busy;
    vec_t vt[9];

    always @(negedge clk) begin
        if (v0 && rdy0) cap0.push_back({d0, pe0, fe0, bk0});
        if (v1 && rdy1) cap1.push_back({d1, pe1, fe1, bk1});
        if (v0) vhi0++;
        if (ov0) ovr0++;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int inst, input logic b);
        if (inst == 0) rx0 = b;
        else           rx1 = b;
    endtask

    // Bit 0 is the start bit; unused upper positions are idle-high.
    task automatic build(input int inst, input logic [7:0] d, input logic pbit,
                         input logic stop_lvl, output logic [15:0] bits, output int n);
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (inst == 0) begin
            bits[9] = stop_lvl;
            n = 10;
        end else begin
            bits[9]  = pbit;
            bits[10] = stop_lvl;
            bits[11] = 1'b1;
            n = 12;
        end
    endtask

    // Caller is aligned at posedge+1; returns aligned the same way.
    task automatic drive_bits(input int inst, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(inst, bits[i]);
            repeat (16) @(posedge clk);
            #1;
        end
        set_line(inst, 1'b1);
    endtask

    task automatic send(input int inst, input logic [7:0] d, input logic pbit, input logic stop_lvl);
        logic [15:0] bits;
        int n;
        build(inst, d, pbit, stop_lvl, bits, n);
        drive_bits(inst, bits, n);
    endtask

    // Reference: even parity means data ones plus parity bit is even.
    function automatic obs_t model(input int inst, input logic [7:0] d, input logic pbit,
                                   input logic stop_lvl);
        obs_t o;
        o.d  = d;
        o.pe = (inst == 1) && (int'(pbit) != ($countones(d) % 2));
        o.fe = !stop_lvl;
        o.bk = (d == 8'h00) && !((inst == 1) && pbit) && !stop_lvl;
        return o;
    endfunction

    task automatic pop_check(input int inst, input string nm, input logic [7:0] ed,
                             input logic [2:0] ef);
        obs_t o;
        int sz;
        sz = (inst == 0) ? cap0.size() : cap1.size();
        check({nm, " count"}, sz, 1);
        if (sz > 0) begin
            o = (inst == 0) ? cap0.pop_front() : cap1.pop_front();
            check({nm, " data"}, int'(o.d), int'(ed));
            check({nm, " flags"}, int'({o.pe, o.fe, o.bk}), int'(ef));
        end
    endtask

    initial begin
        logic [15:0] bits;
        int nb, gap;
        logic [7:0] rd;
        logic rp, rs;
        obs_t o;

        n_cmp = 0; n_bad = 0; vhi0 = 0; ovr0 = 0;
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
        vt[0] = '{0, 8'h5A, 1'b0, 1'b0, 8'h5A, 3'b010};
        vt[1] = '{0, 8'h00, 1'b0, 1'b0, 8'h00, 3'b011};
        vt[2] = '{0, 8'hC3, 1'b0, 1'b1, 8'hC3, 3'b000};
        vt[3] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 3'b100};
        vt[4] = '{1, 8'h03, 1'b0, 1'b1, 8'h03, 3'b000};
        vt[5] = '{1, 8'h80, 1'b1, 1'b1, 8'h80, 3'b000};
        vt[6] = '{1, 8'h00, 1'b0, 1'b0, 8'h00, 3'b011};
        vt[7] = '{1, 8'h00, 1'b1, 1'b0, 8'h00, 3'b110};
        vt[8] = '{1, 8'h7F, 1'b0, 1'b0, 8'h7F, 3'b110};

        idle(3);
        check("reset dut0 outputs", int'({d0, v0, pe0, fe0, bk0, ov0, bz0}), 0);
        check("reset dut1 outputs", int'({d1, v1, pe1, fe1, bk1, ov1, bz1}), 0);
        rst = 1'b0;
        idle(4);

        for (int i = 0; i < 9; i++) begin
            cap0.delete(); cap1.delete();
            send(vt[i].inst, vt[i].d, vt[i].pbit, vt[i].stop_lvl);
            idle(40);
            pop_check(vt[i].inst, $sformatf("vec%0d", i), vt[i].ed, vt[i].eflags);
        end

        // 0xA5 latency: valid must appear between mid stop bit and shortly after its end.
        cap0.delete(); vhi0 = 0;
        fork
            send(0, 8'hA5, 1'b0, 1'b1);
            begin
                lat_k = 0;
                while (!v0 && lat_k < 400) begin
                    @(negedge clk);
                    lat_k++;
                end
                lat = lat_k;
            end
        join
        idle(40);
        check("A5 latency window", int'(lat >= 152 && lat <= 168), 1);
        check("A5 valid pulses", vhi0, 1);
        pop_check(0, "A5", 8'hA5, 3'b000);

        // 5-clk glitch: false start aborted before the start bit would end.
        cap0.delete(); saw_busy = 1'b0;
        rx0 = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk);
                #1 rx0 = 1'b1;
            end
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (bz0) saw_busy = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        check("glitch busy seen", int'(saw_busy), 1);
        check("glitch busy dropped in START", int'(bz0), 0);
        idle(40);
        check("glitch no word", cap0.size(), 0);

        // Line held low for 30 bit times: one break word, no re-arm while low.
        cap0.delete(); rx0 = 1'b0;
        idle(480);
        check("break busy while low", int'(bz0), 0);
        pop_check(0, "break", 8'h00, 3'b011);
        rx0 = 1'b1;
        idle(40);
        check("break nothing after high", cap0.size(), 0);

        // Overrun: second word dropped while first is held.
        cap0.delete(); rdy0 = 1'b0; ovr0 = 0;
        send(0, 8'h11, 1'b0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b1);
        idle(40);
        check("overrun valid held", int'(v0), 1);
        check("overrun data kept", int'(d0), 8'h11);
        check("overrun pulses", ovr0, 1);
        rdy0 = 1'b1;
        idle(3);
        check("overrun valid dropped", int'(v0), 0);
        pop_check(0, "overrun accept", 8'h11, 3'b000);

        // Reset during data bit 4 with a word held.
        rdy0 = 1'b0; cap0.delete();
        send(0, 8'h7E, 1'b0, 1'b1);
        idle(40);
        check("pre-reset valid", int'(v0), 1);
        build(0, 8'h3C, 1'b0, 1'b1, bits, nb);
        drive_bits(0, bits, 5);
        rx0 = bits[5];
        idle(8);
        check("pre-reset busy", int'(bz0), 1);
        rst = 1'b1;
        #2;
        check("mid-frame reset outputs", int'({d0, v0, pe0, fe0, bk0, ov0, bz0}), 0);
        idle(3);
        rx0 = 1'b1;
        rst = 1'b0;
        idle(20);
        rdy0 = 1'b1; cap0.delete();
        send(0, 8'h3C, 1'b0, 1'b1);
        idle(40);
        pop_check(0, "post-reset", 8'h3C, 3'b000);

        // Random frames on both configurations against the reference model.
        for (int inst = 0; inst < 2; inst++) begin
            cap0.delete(); cap1.delete(); exp_q.delete();
            for (int n = 0; n < 25; n++) begin
                rd = 8'($urandom);
                if ($urandom_range(0, 7) == 0) rd = 8'h00;
                rp = (inst == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                rs = ($urandom_range(0, 5) != 0);
                send(inst, rd, rp, rs);
                exp_q.push_back(model(inst, rd, rp, rs));
                gap = rs ? $urandom_range(0, 20) : $urandom_range(16, 40);
                if (gap > 0) idle(gap);
            end
            idle(60);
            check($sformatf("rand dut%0d count", inst),
                  (inst == 0) ? cap0.size() : cap1.size(), exp_q.size());
            while (exp_q.size() > 0 && ((inst == 0) ? cap0.size() : cap1.size()) > 0) begin
                o = (inst == 0) ? cap0.pop_front() : cap1.pop_front();
                check($sformatf("rand dut%0d word", inst), int'(o), int'(exp_q.pop_front()));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
